// File: rtl/io_bridge_pkg.sv
// Shared MMIO map constants and bridge FSM encoding.
// Imported by the bridge, its address decoder and any other MMIO-aware block.
package io_bridge_pkg;

  localparam int unsigned NSLOTS_DEFAULT     = 4;
  localparam logic [31:0] BASE_DEFAULT       = 32'h1000_0000;
  localparam int unsigned SLOT_SHIFT_DEFAULT = 12;

  localparam int unsigned SLOT_GPIO  = 0;
  localparam int unsigned SLOT_UART  = 1;
  localparam int unsigned SLOT_TIMER = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  // Slot index width; kept at least one bit so a single-slot map still has a port.
  function automatic int unsigned slot_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/io_bridge_decode.sv
// Combinational MMIO address decoder: byte address -> {mapped, slot, offset}.
// Shared with the instruction-side fetch guard, so it carries no state.
module io_decode
  import io_bridge_pkg::*;
#(
  parameter int unsigned NSLOTS     = NSLOTS_DEFAULT,
  parameter logic [31:0] BASE       = BASE_DEFAULT,
  parameter int unsigned SLOT_SHIFT = SLOT_SHIFT_DEFAULT,
  localparam int unsigned SW        = slot_w(NSLOTS)
) (
  input  logic [31:0]   addr,
  output logic          mapped,
  output logic [SW-1:0] slot,
  output logic [31:0]   offset
);

  localparam logic [31:0] OFF_MASK = (32'd1 << SLOT_SHIFT) - 32'd1;

  logic [31:0] rel;
  logic [31:0] slot_full;

  // The addr >= BASE term keeps addresses below BASE from wrapping into a slot.
  always_comb begin
    rel       = addr - BASE;
    slot_full = rel >> SLOT_SHIFT;
    mapped    = (addr >= BASE) && (slot_full < NSLOTS);
    slot      = slot_full[SW-1:0];
    offset    = rel & OFF_MASK;
  end

endmodule

// File: rtl/io_bridge.sv
// Registered MMIO bridge: one CPU request -> one-cycle peripheral strobe -> one response.
// Fixed latency: accept at N, bus access at N+1, response at N+2, ready again at N+3.
module io_bridge
  import io_bridge_pkg::*;
#(
  parameter int unsigned NSLOTS     = NSLOTS_DEFAULT,
  parameter logic [31:0] BASE       = BASE_DEFAULT,
  parameter int unsigned SLOT_SHIFT = SLOT_SHIFT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cpu_req_valid,
  output logic                 cpu_req_ready,
  input  logic [31:0]          cpu_req_addr,
  input  logic                 cpu_req_write,
  input  logic [3:0]           cpu_req_mask,
  input  logic [31:0]          cpu_req_wdata,
  output logic                 cpu_resp_valid,
  output logic [31:0]          cpu_resp_rdata,
  output logic                 cpu_resp_err,
  output logic [NSLOTS-1:0]    io_sel,
  output logic [31:0]          io_addr,
  output logic                 io_op,
  output logic [3:0]           io_mask,
  output logic [31:0]          io_wdata,
  input  logic [32*NSLOTS-1:0] io_rdata
);

  localparam int unsigned SW = slot_w(NSLOTS);

  logic          dec_mapped;
  logic [SW-1:0] dec_slot;
  logic [31:0]   dec_offset;

  io_decode #(
    .NSLOTS     (NSLOTS),
    .BASE       (BASE),
    .SLOT_SHIFT (SLOT_SHIFT)
  ) u_decode (
    .addr   (cpu_req_addr),
    .mapped (dec_mapped),
    .slot   (dec_slot),
    .offset (dec_offset)
  );

  state_e             state_q, state_d;
  logic               mapped_q, mapped_d;
  logic               write_q, write_d;
  logic [SW-1:0]      slot_q, slot_d;
  logic               ready_q, ready_d;
  logic [NSLOTS-1:0]  io_sel_q, io_sel_d;
  logic               io_op_q, io_op_d;
  logic [31:0]        io_addr_q, io_addr_d;
  logic [3:0]         io_mask_q, io_mask_d;
  logic [31:0]        io_wdata_q, io_wdata_d;
  logic               resp_valid_q, resp_valid_d;
  logic               resp_err_q, resp_err_d;
  logic [31:0]        resp_rdata_q, resp_rdata_d;
  logic [31:0]        rdata_sel;

  always_comb begin
    rdata_sel = '0;
    for (int k = 0; k < NSLOTS; k++) begin
      if (slot_q == SW'(k)) rdata_sel = io_rdata[32*k +: 32];
    end
  end

  always_comb begin
    state_d      = state_q;
    mapped_d     = mapped_q;
    write_d      = write_q;
    slot_d       = slot_q;
    ready_d      = ready_q;
    io_sel_d     = io_sel_q;
    io_op_d      = io_op_q;
    io_addr_d    = io_addr_q;
    io_mask_d    = io_mask_q;
    io_wdata_d   = io_wdata_q;
    resp_valid_d = resp_valid_q;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (cpu_req_valid) begin
          // Bus outputs load on the accept edge so the strobe lands exactly in N+1.
          state_d    = ST_ACCESS;
          ready_d    = 1'b0;
          mapped_d   = dec_mapped;
          write_d    = cpu_req_write;
          slot_d     = dec_slot;
          io_sel_d   = dec_mapped ? (NSLOTS'(1) << dec_slot) : '0;
          io_op_d    = dec_mapped & cpu_req_write;
          io_addr_d  = dec_offset;
          io_mask_d  = cpu_req_mask;
          io_wdata_d = cpu_req_wdata;
        end
      end
      ST_ACCESS: begin
        state_d      = ST_RESP;
        io_sel_d     = '0;
        io_op_d      = 1'b0;
        resp_valid_d = 1'b1;
        resp_err_d   = !mapped_q;
        resp_rdata_d = (mapped_q && !write_q) ? rdata_sel : 32'd0;
      end
      ST_RESP: begin
        state_d      = ST_IDLE;
        ready_d      = 1'b1;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = 32'd0;
      end
      default: begin
        state_d      = ST_IDLE;
        ready_d      = 1'b1;
        io_sel_d     = '0;
        io_op_d      = 1'b0;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = 32'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      mapped_q     <= 1'b0;
      write_q      <= 1'b0;
      slot_q       <= '0;
      ready_q      <= 1'b1;
      io_sel_q     <= '0;
      io_op_q      <= 1'b0;
      io_addr_q    <= 32'd0;
      io_mask_q    <= 4'd0;
      io_wdata_q   <= 32'd0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      mapped_q     <= mapped_d;
      write_q      <= write_d;
      slot_q       <= slot_d;
      ready_q      <= ready_d;
      io_sel_q     <= io_sel_d;
      io_op_q      <= io_op_d;
      io_addr_q    <= io_addr_d;
      io_mask_q    <= io_mask_d;
      io_wdata_q   <= io_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign cpu_req_ready  = ready_q;
  assign cpu_resp_valid = resp_valid_q;
  assign cpu_resp_err   = resp_err_q;
  assign cpu_resp_rdata = resp_rdata_q;
  assign io_sel         = io_sel_q;
  assign io_op          = io_op_q;
  assign io_addr        = io_addr_q;
  assign io_mask        = io_mask_q;
  assign io_wdata       = io_wdata_q;

endmodule

// File: tb/tb_io_bridge.sv
// Scoreboard bench for io_bridge: drivers queue expected bus strobes and responses,
// negedge monitors pop and compare them with cycle-accurate timing.
module tb_io_bridge;

  logic         clk = 1'b0;
  logic         rst;
  logic         cpu_req_valid;
  logic         cpu_req_ready;
  logic [31:0]  cpu_req_addr;
  logic         cpu_req_write;
  logic [3:0]   cpu_req_mask;
  logic [31:0]  cpu_req_wdata;
  logic         cpu_resp_valid;
  logic [31:0]  cpu_resp_rdata;
  logic         cpu_resp_err;
  logic [3:0]   io_sel;
  logic [31:0]  io_addr;
  logic         io_op;
  logic [3:0]   io_mask;
  logic [31:0]  io_wdata;
  logic [127:0] io_rdata;

  io_bridge dut (
    .clk            (clk),
    .rst            (rst),
    .cpu_req_valid  (cpu_req_valid),
    .cpu_req_ready  (cpu_req_ready),
    .cpu_req_addr   (cpu_req_addr),
    .cpu_req_write  (cpu_req_write),
    .cpu_req_mask   (cpu_req_mask),
    .cpu_req_wdata  (cpu_req_wdata),
    .cpu_resp_valid (cpu_resp_valid),
    .cpu_resp_rdata (cpu_resp_rdata),
    .cpu_resp_err   (cpu_resp_err),
    .io_sel         (io_sel),
    .io_addr        (io_addr),
    .io_op          (io_op),
    .io_mask        (io_mask),
    .io_wdata       (io_wdata),
    .io_rdata       (io_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int          cyc;
    logic [3:0]  sel;
    logic        op;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] wdata;
  } io_exp_t;

  typedef struct {
    int          cyc;
    logic        err;
    logic [31:0] rdata;
  } resp_exp_t;

  io_exp_t   io_q[$];
  resp_exp_t resp_q[$];

  // Bus monitor: any cycle with a select or strobe must match a queued expectation.
  always @(negedge clk) begin
    if (rst && (io_sel != 4'd0 || io_op)) begin
      tests++;
      if (io_q.size() == 0) begin
        fails++;
        $display("[TB] FAIL io_unexpected cyc=%0d got sel=%b op=%b required no bus activity",
                 cyc, io_sel, io_op);
      end else begin
        io_exp_t e;
        e = io_q.pop_front();
        if (cyc != e.cyc || io_sel != e.sel || io_op != e.op || io_addr != e.addr ||
            io_mask != e.mask || io_wdata != e.wdata) begin
          fails++;
          $display("[TB] FAIL io_access got cyc=%0d sel=%b op=%b addr=%h mask=%h wdata=%h required cyc=%0d sel=%b op=%b addr=%h mask=%h wdata=%h",
                   cyc, io_sel, io_op, io_addr, io_mask, io_wdata,
                   e.cyc, e.sel, e.op, e.addr, e.mask, e.wdata);
        end else begin
          $display("[TB] io   cyc=%0d sel=%b op=%b addr=%h mask=%h wdata=%h ok",
                   cyc, io_sel, io_op, io_addr, io_mask, io_wdata);
        end
      end
    end
  end

  // Response monitor.
  always @(negedge clk) begin
    if (rst && cpu_resp_valid) begin
      tests++;
      if (resp_q.size() == 0) begin
        fails++;
        $display("[TB] FAIL resp_unexpected cyc=%0d got err=%b rdata=%h required no response",
                 cyc, cpu_resp_err, cpu_resp_rdata);
      end else begin
        resp_exp_t r;
        r = resp_q.pop_front();
        if (cyc != r.cyc || cpu_resp_err != r.err || cpu_resp_rdata != r.rdata) begin
          fails++;
          $display("[TB] FAIL resp got cyc=%0d err=%b rdata=%h required cyc=%0d err=%b rdata=%h",
                   cyc, cpu_resp_err, cpu_resp_rdata, r.cyc, r.err, r.rdata);
        end else begin
          $display("[TB] resp cyc=%0d err=%b rdata=%h ok", cyc, cpu_resp_err, cpu_resp_rdata);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    tests++;
    if (got !== req) begin
      fails++;
      $display("[TB] FAIL %s got=%h required=%h", name, got, req);
    end else begin
      $display("[TB] %s = %h ok", name, got);
    end
  endtask

  // Issue one request (called #1 after a posedge) and queue its expected effects.
  task automatic do_req(input logic [31:0] a, input logic w, input logic [3:0] m,
                        input logic [31:0] wd, input logic mp, input logic [3:0] sel,
                        input logic [31:0] off, input logic [31:0] rd, input bit drop,
                        output int acc);
    io_exp_t   e;
    resp_exp_t r;
    cpu_req_valid = 1'b1;
    cpu_req_addr  = a;
    cpu_req_write = w;
    cpu_req_mask  = m;
    cpu_req_wdata = wd;
    acc = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cpu_req_ready) begin
        acc = cyc;
        break;
      end
    end
    if (acc < 0) begin
      tests++;
      fails++;
      $display("[TB] FAIL accept_timeout addr=%h got ready=0 required ready=1 within 20 cycles", a);
    end else begin
      if (mp) begin
        e.cyc = acc + 1; e.sel = sel; e.op = w; e.addr = off; e.mask = m; e.wdata = wd;
        io_q.push_back(e);
      end
      r.cyc = acc + 2;
      r.err = !mp;
      r.rdata = (mp && !w) ? rd : 32'd0;
      resp_q.push_back(r);
    end
    @(posedge clk);
    #1;
    if (drop) cpu_req_valid = 1'b0;
  endtask

  initial begin
    int a0, a1, a2;
    rst           = 1'b0;
    cpu_req_valid = 1'b0;
    cpu_req_addr  = 32'd0;
    cpu_req_write = 1'b0;
    cpu_req_mask  = 4'd0;
    cpu_req_wdata = 32'd0;
    io_rdata      = {32'h4444_4444, 32'h3333_3333, 32'hCAFE_F00D, 32'h1111_1111};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_ready_respv_err", {61'd0, cpu_req_ready, cpu_resp_valid, cpu_resp_err}, 64'd4);
    check("reset_rdata", {32'd0, cpu_resp_rdata}, 64'd0);
    check("reset_sel_op_mask", {55'd0, io_sel, io_op, io_mask}, 64'd0);
    check("reset_addr_wdata", {io_addr, io_wdata}, 64'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;

    // GPIO store, UART load, slot 3 and GPIO loads.
    do_req(32'h1000_0000, 1'b1, 4'hF, 32'h0000_0003, 1'b1, 4'b0001, 32'h0, 32'h0, 1'b1, a0);
    do_req(32'h1000_1004, 1'b0, 4'hF, 32'h0, 1'b1, 4'b0010, 32'h4, 32'hCAFE_F00D, 1'b1, a0);
    do_req(32'h1000_3020, 1'b0, 4'h3, 32'h0, 1'b1, 4'b1000, 32'h20, 32'h4444_4444, 1'b1, a0);
    do_req(32'h1000_0008, 1'b0, 4'hF, 32'h0, 1'b1, 4'b0001, 32'h8, 32'h1111_1111, 1'b1, a0);
    // Unmapped: past the last slot, and just below BASE.
    do_req(32'h1000_4000, 1'b1, 4'hF, 32'hDEAD_BEEF, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b1, a0);
    do_req(32'h0FFF_FFFC, 1'b0, 4'hF, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b1, a0);
    // Zero-mask store, misaligned offset.
    do_req(32'h1000_2013, 1'b1, 4'h0, 32'h0000_00A5, 1'b1, 4'b0100, 32'h13, 32'h0, 1'b1, a0);

    // Valid held high across three stores: accepts three cycles apart.
    do_req(32'h1000_1000, 1'b1, 4'hF, 32'h0000_0001, 1'b1, 4'b0010, 32'h0, 32'h0, 1'b0, a0);
    do_req(32'h1000_1004, 1'b1, 4'hF, 32'h0000_0002, 1'b1, 4'b0010, 32'h4, 32'h0, 1'b0, a1);
    do_req(32'h1000_1008, 1'b1, 4'hF, 32'h0000_0003, 1'b1, 4'b0010, 32'h8, 32'h0, 1'b1, a2);
    check("b2b_accept_gap_1", 64'(a1 - a0), 64'd3);
    check("b2b_accept_gap_2", 64'(a2 - a1), 64'd3);

    repeat (4) @(posedge clk);
    #1;

    // Reset during ACCESS of a store: strobe drops at once, no response follows.
    cpu_req_valid = 1'b1;
    cpu_req_addr  = 32'h1000_1000;
    cpu_req_write = 1'b1;
    cpu_req_mask  = 4'hF;
    cpu_req_wdata = 32'h0000_0077;
    @(negedge clk);
    check("rst_pre_ready", {63'd0, cpu_req_ready}, 64'd1);
    @(posedge clk);
    #1 cpu_req_valid = 1'b0;
    check("rst_access_op", {60'd0, io_sel}, 64'h2);
    rst = 1'b0;
    #1;
    check("rst_async_sel_op", {59'd0, io_sel, io_op}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst_release_ready", {63'd0, cpu_req_ready}, 64'd1);
    repeat (6) @(posedge clk);
    #1;

    // A normal access after reset still works.
    do_req(32'h1000_2004, 1'b0, 4'hF, 32'h0, 1'b1, 4'b0100, 32'h4, 32'h3333_3333, 1'b1, a0);

    for (int i = 0; i < 20 && (io_q.size() != 0 || resp_q.size() != 0); i++) @(posedge clk);
    repeat (3) @(posedge clk);
    tests++;
    if (io_q.size() != 0 || resp_q.size() != 0) begin
      fails++;
      $display("[TB] FAIL drain got io_pending=%0d resp_pending=%0d required 0 and 0",
               io_q.size(), resp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
